core_mem_ctrl: RTL and testbench

- Memory controller directly downstream of the CPU core's memory port. Replaces the core's single-cycle memory assumption with a valid/ready request and response handshake.
- Converts each core request into a timed asynchronous-SRAM cycle (chip enable, output enable, write enable, tri-state data) with programmable wait states.
- Optionally decodes one memory-mapped display register that feeds the seven-segment mux.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/mem_wait_timer.sv | 42 ++++
 rtl/core_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_core_mem_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset vector and memory-controller state type.
// Imported by the memory controller and its wait-state timer.
package cpu_pkg;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] PC_START = 24'd9216;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      DONE
   } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: loadable down-counter with zero flag for SRAM wait states.
// Ports: clk, reset (async, high), load_i, dec_i, zero_o.
module mem_wait_timer #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int CW = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

   if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("mem_wait_timer: WAIT_CYCLES must be at least 1");
   end

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/core_mem_ctrl.sv
// core_mem_ctrl: core valid/ready port to timed async-SRAM cycle sequencer.
// Ports: clk, reset (async, high); req_* in, req_ready/rsp_* out;
// mem_* SRAM pins (all registered); disp_value only with MEM_CTRL_MMIO_EN.
module core_mem_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int WAIT_CYCLES = 2,
   parameter logic [ADDR_W-1:0] MMIO_ADDR = 24'hFFFFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic [DATA_W-1:0] mem_dq_out,
   output logic              mem_dq_oe,
   input  logic [DATA_W-1:0] mem_dq_in
`ifdef MEM_CTRL_MMIO_EN
   ,
   output logic [DATA_W-1:0] disp_value
`endif
);

   mem_state_t        state_q;
   logic              we_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] addr_q;
   logic              ce_n_q;
   logic              oe_n_q;
   logic              we_n_q;
   logic [DATA_W-1:0] dq_out_q;
   logic              dq_oe_q;
   logic              tmr_zero;

`ifdef MEM_CTRL_MMIO_EN
   logic [DATA_W-1:0] disp_q;
   assign disp_value = disp_q;
`else
   logic unused_mmio;
   assign unused_mmio = ^MMIO_ADDR;
`endif

   mem_wait_timer #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_tmr (
      .clk   (clk),
      .reset (reset),
      .load_i(state_q == SETUP),
      .dec_i (state_q == ACCESS),
      .zero_o(tmr_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         addr_q      <= '0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
`ifdef MEM_CTRL_MMIO_EN
         disp_q      <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
`ifdef MEM_CTRL_MMIO_EN
                  if (req_addr == MMIO_ADDR) begin
                     // Display register: answer at once, SRAM untouched.
                     state_q     <= DONE;
                     rsp_valid_q <= 1'b1;
                     if (req_we) begin
                        disp_q <= req_wdata;
                     end else begin
                        rdata_q <= disp_q;
                     end
                  end else begin
`endif
                     state_q <= SETUP;
                     we_q    <= req_we;
                     addr_q  <= req_addr;
                     ce_n_q  <= 1'b0;
                     if (req_we) begin
                        dq_out_q <= req_wdata;
                        dq_oe_q  <= 1'b1;
                     end
`ifdef MEM_CTRL_MMIO_EN
                  end
`endif
               end
            end
            SETUP: begin
               state_q <= ACCESS;
               if (we_q) begin
                  we_n_q <= 1'b0;
               end else begin
                  oe_n_q <= 1'b0;
               end
            end
            ACCESS: begin
               if (tmr_zero) begin
                  state_q     <= DONE;
                  oe_n_q      <= 1'b1;
                  we_n_q      <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  if (!we_q) begin
                     rdata_q <= mem_dq_in;
                  end
               end
            end
            DONE: begin
               // Data stays driven through DONE for write hold time.
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               ce_n_q      <= 1'b1;
               dq_oe_q     <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rdata_q;
   assign mem_addr   = addr_q;
   assign mem_ce_n   = ce_n_q;
   assign mem_oe_n   = oe_n_q;
   assign mem_we_n   = we_n_q;
   assign mem_dq_out = dq_out_q;
   assign mem_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_core_mem_ctrl.sv
// tb_core_mem_ctrl: self-checking bench for core_mem_ctrl (WAIT_CYCLES 2 and 1).
// Uses a behavioural SRAM and a memory-semantics scoreboard.
module tb_core_mem_ctrl;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [23:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        req_ready;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [23:0] mem_addr;
   logic        mem_ce_n;
   logic        mem_oe_n;
   logic        mem_we_n;
   logic [15:0] mem_dq_out;
   logic        mem_dq_oe;
   logic [15:0] mem_dq_in = '0;
`ifdef MEM_CTRL_MMIO_EN
   logic [15:0] disp_value;
   logic [15:0] disp1;
`endif

   logic        r1_valid = 1'b0;
   logic        r1_we = 1'b0;
   logic [23:0] r1_addr = '0;
   logic [15:0] r1_wdata = '0;
   logic        r1_ready;
   logic        r1_rsp_valid;
   logic [15:0] r1_rdata;
   logic [23:0] m1_addr;
   logic        m1_ce_n;
   logic        m1_oe_n;
   logic        m1_we_n;
   logic [15:0] m1_dq_out;
   logic        m1_dq_oe;
   logic [15:0] m1_dq_in = 16'h7E57;

   int n_checks = 0;
   int n_err = 0;

   logic [15:0] sram [logic [23:0]];
   logic [15:0] exp_mem [logic [23:0]];
   logic [15:0] last_rd = '0;

   core_mem_ctrl #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
      .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n),
      .mem_we_n(mem_we_n), .mem_dq_out(mem_dq_out),
      .mem_dq_oe(mem_dq_oe), .mem_dq_in(mem_dq_in)
`ifdef MEM_CTRL_MMIO_EN
      , .disp_value(disp_value)
`endif
   );

   core_mem_ctrl #(.WAIT_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(r1_valid), .req_we(r1_we),
      .req_addr(r1_addr), .req_wdata(r1_wdata),
      .req_ready(r1_ready), .rsp_valid(r1_rsp_valid),
      .rsp_rdata(r1_rdata), .mem_addr(m1_addr),
      .mem_ce_n(m1_ce_n), .mem_oe_n(m1_oe_n),
      .mem_we_n(m1_we_n), .mem_dq_out(m1_dq_out),
      .mem_dq_oe(m1_dq_oe), .mem_dq_in(m1_dq_in)
`ifdef MEM_CTRL_MMIO_EN
      , .disp_value(disp1)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] dflt(input logic [23:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] model_rd(input logic [23:0] a);
      if (exp_mem.exists(a)) return exp_mem[a];
      return dflt(a);
   endfunction

   // Behavioural asynchronous SRAM on the bus.
   always @(posedge clk) begin
      if (!mem_ce_n && !mem_we_n && mem_dq_oe) sram[mem_addr] = mem_dq_out;
   end

   always @(negedge clk) begin
      if (!mem_ce_n && !mem_oe_n)
         mem_dq_in = sram.exists(mem_addr) ? sram[mem_addr] : dflt(mem_addr);
      else
         mem_dq_in = 16'h0000;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [23:0] a, input logic [15:0] wd,
                         output int lat, output int oe_c, output int we_c,
                         output int dq_c, output int ce_c, output logic [15:0] rd,
                         output bit ok_seq, output bit ok_post);
      int n;
      bit done;
      lat = -1; oe_c = 0; we_c = 0; dq_c = 0; ce_c = 0;
      rd = '0; ok_seq = 1; ok_post = 0; done = 0;
      @(negedge clk);
      req_valid = 1; req_we = we; req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 0;
      req_we = 1'($urandom_range(0, 1));
      req_addr = 24'($urandom);
      req_wdata = 16'($urandom);
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            done = 1; lat = c; rd = rsp_rdata;
         end
         if (!mem_oe_n) oe_c++;
         if (!mem_we_n) we_c++;
         if (mem_dq_oe) dq_c++;
         if (!mem_ce_n) ce_c++;
         if (!mem_ce_n && mem_addr !== a) ok_seq = 0;
         if (c == 0 && !done && !(mem_we_n && mem_oe_n)) ok_seq = 0;
         if (!mem_we_n && mem_dq_out !== wd) ok_seq = 0;
         if (!mem_oe_n && !mem_we_n) ok_seq = 0;
         if (req_ready && !done) ok_seq = 0;
      end
      @(negedge clk);
      ok_post = !rsp_valid && req_ready && mem_ce_n && !mem_dq_oe && mem_oe_n && mem_we_n;
   endtask

   typedef struct {
      logic        we;
      logic [23:0] addr;
      logic [15:0] wd;
      logic [15:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t tbl [9];
   logic [23:0] pool [8];

   initial begin
      int lat, oe_c, we_c, dq_c, ce_c, seen;
      logic [15:0] rd;
      bit ok_seq, ok_post;
      int acc0, acc1, lowcnt, pulses;
      bit addr_stable, got_rd, accepted;
      logic [15:0] rd_b;

      tbl[0] = '{1'b0, 24'h002401, 16'h0000, 16'hBEEF, W + 1};
      tbl[1] = '{1'b1, 24'h000010, 16'h1234, 16'hBEEF, W + 1};
      tbl[2] = '{1'b0, 24'h000010, 16'h0000, 16'h1234, W + 1};
      tbl[3] = '{1'b0, 24'h000000, 16'h0000, 16'h5A5A, W + 1};
      tbl[4] = '{1'b1, 24'h00ABCD, 16'h0F0F, 16'h5A5A, W + 1};
      tbl[5] = '{1'b1, 24'h000011, 16'h8001, 16'h5A5A, W + 1};
      tbl[6] = '{1'b0, 24'h00ABCD, 16'h0000, 16'h0F0F, W + 1};
      tbl[7] = '{1'b0, 24'h000011, 16'h0000, 16'h8001, W + 1};
      tbl[8] = '{1'b0, 24'h123456, 16'h0000, 16'h6E0C, W + 1};
      pool = '{24'h000020, 24'h000030, 24'h000010, 24'h000011,
               24'h00ABCD, 24'h000040, 24'h7FFFF0, 24'hFFFFFE};
      sram[24'h002401] = 16'hBEEF;
      exp_mem[24'h002401] = 16'hBEEF;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
      chk("rst_dq_oe", mem_dq_oe, 0);
      chk("rst_dq_out", mem_dq_out, 0);
      reset = 0;

      // Reset in the middle of a write's ACCESS phase
      @(negedge clk);
      req_valid = 1; req_we = 1; req_addr = 24'h002400; req_wdata = 16'hCAFE;
      @(posedge clk);
      #1 req_valid = 0;
      @(negedge clk);
      @(posedge clk);
      #2;
      chk("abort_pre_we_n", mem_we_n, 0);
      reset = 1;
      #1;
      chk("abort_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
      chk("abort_dq_oe", mem_dq_oe, 0);
      chk("abort_rsp", rsp_valid, 0);
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("abort_ready", req_ready, 1);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("abort_no_rsp", seen, 0);

      // Table-driven single transactions
      for (int i = 0; i < 9; i++) begin
         do_req(tbl[i].we, tbl[i].addr, tbl[i].wd,
                lat, oe_c, we_c, dq_c, ce_c, rd, ok_seq, ok_post);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
         chk($sformatf("tbl%0d_oe_cyc", i), oe_c, tbl[i].we ? 0 : W);
         chk($sformatf("tbl%0d_we_cyc", i), we_c, tbl[i].we ? W : 0);
         chk($sformatf("tbl%0d_dqoe_cyc", i), dq_c, tbl[i].we ? W + 2 : 0);
         chk($sformatf("tbl%0d_ce_cyc", i), ce_c, W + 2);
         chk($sformatf("tbl%0d_seq", i), ok_seq, 1);
         chk($sformatf("tbl%0d_post", i), ok_post, 1);
         if (tbl[i].we) exp_mem[tbl[i].addr] = tbl[i].wd;
         else last_rd = tbl[i].exp_rd;
      end

      // Back-to-back: read then write with req_valid held
      acc0 = -1; acc1 = -1; lowcnt = 0; pulses = 0;
      addr_stable = 1; got_rd = 0; rd_b = '0;
      @(negedge clk);
      req_valid = 1; req_we = 0; req_addr = 24'h000020; req_wdata = 16'h0000;
      for (int c = 0; c < 30; c++) begin
         if (rsp_valid) begin
            pulses++;
            if (!got_rd) begin
               got_rd = 1; rd_b = rsp_rdata;
            end
         end
         if (acc0 >= 0 && acc1 < 0) begin
            if (!req_ready) lowcnt++;
            if (!mem_ce_n && mem_addr !== 24'h000020) addr_stable = 0;
         end
         accepted = req_ready && req_valid;
         @(posedge clk);
         #1;
         if (accepted) begin
            if (acc0 < 0) begin
               acc0 = c;
               req_we = 1; req_addr = 24'h000030; req_wdata = 16'h5555;
            end else if (acc1 < 0) begin
               acc1 = c;
               req_valid = 0; req_addr = 24'h0000FF;
            end
         end
         @(negedge clk);
      end
      chk("b2b_spacing", acc1 - acc0, W + 3);
      chk("b2b_ready_low", lowcnt, W + 2);
      chk("b2b_addr_stable", addr_stable, 1);
      chk("b2b_pulses", pulses, 2);
      chk("b2b_rdata", rd_b, model_rd(24'h000020));
      last_rd = model_rd(24'h000020);
      exp_mem[24'h000030] = 16'h5555;

      // WAIT_CYCLES = 1 instance
      @(negedge clk);
      chk("w1_ready", r1_ready, 1);
      r1_valid = 1; r1_we = 0; r1_addr = 24'h000123;
      @(posedge clk);
      #1 r1_valid = 0;
      oe_c = 0; lat = -1; rd = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!m1_oe_n) oe_c++;
         if (r1_rsp_valid && lat < 0) begin
            lat = c; rd = r1_rdata;
         end
      end
      chk("w1_oe_cyc", oe_c, 1);
      chk("w1_lat", lat, 2);
      chk("w1_rdata", rd, 16'h7E57);

      // Randomised traffic against the memory-semantics model
      for (int i = 0; i < 40; i++) begin
         logic        we;
         logic [23:0] a;
         logic [15:0] wd;
         logic [15:0] exp_rd;
         we = 1'($urandom_range(0, 1));
         a = pool[$urandom_range(0, 7)];
         wd = 16'($urandom);
         exp_rd = we ? last_rd : model_rd(a);
         do_req(we, a, wd, lat, oe_c, we_c, dq_c, ce_c, rd, ok_seq, ok_post);
         chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
         chk($sformatf("rnd%0d_lat", i), lat, W + 1);
         chk($sformatf("rnd%0d_strobes", i), {oe_c[7:0], we_c[7:0], dq_c[7:0], ce_c[7:0]},
             {8'(we ? 0 : W), 8'(we ? W : 0), 8'(we ? W + 2 : 0), 8'(W + 2)});
         chk($sformatf("rnd%0d_seq", i), {ok_seq, ok_post}, 2'b11);
         if (we) exp_mem[a] = wd;
         else last_rd = exp_rd;
      end

`ifdef MEM_CTRL_MMIO_EN
      // Display register access bypasses the SRAM
      do_req(1, 24'hFFFFFF, 16'h00A5, lat, oe_c, we_c, dq_c, ce_c, rd, ok_seq, ok_post);
      chk("mmio_w_lat", lat, 0);
      chk("mmio_w_ce", ce_c, 0);
      chk("mmio_w_post", ok_post, 1);
      chk("mmio_disp", disp_value, 16'h00A5);
      do_req(0, 24'hFFFFFF, 16'h0000, lat, oe_c, we_c, dq_c, ce_c, rd, ok_seq, ok_post);
      chk("mmio_r_lat", lat, 0);
      chk("mmio_r_ce", ce_c, 0);
      chk("mmio_r_rdata", rd, 16'h00A5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
